rr_arbiter_4: RTL and testbench

//   Four-way round-robin arbiter with grant hold and timeout for a shared single-owner resource,

---
 rtl/rr_arbiter_4.sv | 122 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with grant hold and hold timeout.
// One requester owns the shared resource at a time until it signals done,
// drops its request, or exceeds MAX_HOLD cycles of ownership.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; gnt = 0, gnt_idx holds the last owner
// BUSY  | owner gnt_idx holds the resource, cnt counts cycles held
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Last count value before a forced release; unused when MAX_HOLD = 0.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       own_done;
  logic       own_req;
  logic       hold_hit;
  logic       rel;
  logic       timeout_cause;
  logic [1:0] scan_base;
  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_vld;

  // Release decision for the current owner; the scan base moves past the
  // releasing owner so it re-enters arbitration at lowest priority.
  always_comb begin
    own_done      = done[gnt_idx];
    own_req       = req[gnt_idx];
    hold_hit      = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    rel           = (state == BUSY) && (own_done || !own_req || hold_hit);
    timeout_cause = rel && !own_done && own_req;
    scan_base     = rel ? gnt_idx + 2'd1 : ptr;
  end

  // Rotating priority scan: walk from the farthest offset down so the
  // requester nearest scan_base is the one left in win_idx.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = scan_base;
    scan_idx = scan_base;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = scan_base + 2'(k);
      if (req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Grant FSM with registered outputs, hold counter and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_vld) begin
            state   <= BUSY;
            gnt     <= 4'b0001 << win_idx;
            gnt_idx <= win_idx;
            gnt_vld <= 1'b1;
            cnt     <= '0;
          end else begin
            gnt     <= 4'b0000;
            gnt_vld <= 1'b0;
          end
        end
        BUSY: begin
          timeout <= timeout_cause;
          if (rel) begin
            ptr <= gnt_idx + 2'd1;
            if (win_vld) begin
              gnt     <= 4'b0001 << win_idx;
              gnt_idx <= win_idx;
              gnt_vld <= 1'b1;
              cnt     <= '0;
            end else begin
              state   <= IDLE;
              gnt     <= 4'b0000;
              gnt_vld <= 1'b0;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= 4'b0000;
          gnt_vld <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 built with MAX_HOLD = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int vectors;
  int miscompares;

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Check all outputs against a hand-computed grant, index and timeout.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic to);
    chk({tag, ".gnt"}, {4'b0, gnt}, {4'b0, g});
    chk({tag, ".vld"}, {7'b0, gnt_vld}, {7'b0, (g != 4'b0000)});
    chk({tag, ".idx"}, {6'b0, gnt_idx}, {6'b0, idx});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, to});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] e;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    #12;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    tick;
    rst_n = 1'b1;

    // Single request, release by done with request dropping.
    req = 4'b0001;
    tick;
    expect_out("t2_grant", 4'b0001, 2'd0, 1'b0);
    tick;
    expect_out("t2_hold_c2", 4'b0001, 2'd0, 1'b0);
    tick;
    expect_out("t2_hold_c3", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    req  = 4'b0000;
    tick;
    done = 4'b0000;
    expect_out("t2_release", 4'b0000, 2'd0, 1'b0);

    // done strobes while idle are ignored.
    done = 4'b1111;
    tick;
    expect_out("t6_idle_done_a", 4'b0000, 2'd0, 1'b0);
    tick;
    expect_out("t6_idle_done_b", 4'b0000, 2'd0, 1'b0);
    done = 4'b0000;

    // Async reset mid-transaction; pointer returns to 0.
    req = 4'b0010;
    tick;
    expect_out("t1_grant", 4'b0010, 2'd1, 1'b0);
    tick;
    expect_out("t1_busy", 4'b0010, 2'd1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("t1_async", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111;
    tick;
    expect_out("t1_in_reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick;

    // Fairness: each owner pulses done two cycles after its grant.
    for (int n = 0; n < 5; n++) begin
      e = 2'(n % 4);
      expect_out($sformatf("t3_g%0d_c0", n), 4'b0001 << e, e, 1'b0);
      tick;
      expect_out($sformatf("t3_g%0d_c1", n), 4'b0001 << e, e, 1'b0);
      tick;
      expect_out($sformatf("t3_g%0d_c2", n), 4'b0001 << e, e, 1'b0);
      done = 4'b0001 << e;
      if (n == 4) req = 4'b0000;
      tick;
      done = 4'b0000;
    end
    expect_out("t3_idle", 4'b0000, 2'd0, 1'b0);

    // Timeout with two contenders (pointer now at 1).
    req = 4'b0110;
    tick;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("t4_own1_c%0d", i), 4'b0010, 2'd1, 1'b0);
      tick;
    end
    expect_out("t4_to_1", 4'b0100, 2'd2, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick;
      expect_out($sformatf("t4_own2_c%0d", i), 4'b0100, 2'd2, 1'b0);
    end
    tick;
    expect_out("t4_back", 4'b0010, 2'd1, 1'b1);

    // Non-owner done and non-owner request changes have no effect.
    done = 4'b0100;
    tick;
    done = 4'b0000;
    expect_out("t6_nonowner_done", 4'b0010, 2'd1, 1'b0);
    req = 4'b1110;
    tick;
    expect_out("t6_nonowner_req", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    tick;
    expect_out("t6_drop_idle", 4'b0000, 2'd1, 1'b0);

    // Pointer wrap 3 -> 0, then sole requester is re-granted.
    req = 4'b1000;
    tick;
    expect_out("t5_own3", 4'b1000, 2'd3, 1'b0);
    req  = 4'b1001;
    done = 4'b1000;
    tick;
    done = 4'b0000;
    expect_out("t5_wrap", 4'b0001, 2'd0, 1'b0);
    req  = 4'b0001;
    done = 4'b0001;
    tick;
    done = 4'b0000;
    expect_out("t5_regrant", 4'b0001, 2'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick;
      expect_out($sformatf("t5_hold_c%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    tick;
    expect_out("t5_solo_timeout", 4'b0001, 2'd0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick;
      expect_out($sformatf("t5_hold2_c%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    // done coincides with the hold limit: treated as done, no pulse.
    done = 4'b0001;
    tick;
    done = 4'b0000;
    expect_out("t5_done_beats_to", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick;
    expect_out("t5_idle", 4'b0000, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
